mdu_arbiter: RTL and testbench
==============================

// Module: mdu_arbiter
// PURPOSE
// Shares one multi-cycle mul unit and one div unit between the two issue slots of the EX stage.
// - Slot 0 is older; pending requests are serialized slot 0 first, then slot 1.
// - Drives the unit start pulses and holds operands stable while a unit runs.
// - Captures and sign-extends results, stalls EX until every valid request in the stage is done.
// - Aborts an in-flight operation on exception.
// PARAMETERS
// XLEN      64   datapath width; word32 mode uses the low 32 bits
// PORTS
// clk            in   1        clock, rising edge
// rst            in   1        asynchronous, active-low reset (0 = reset)
// except         in   1        exception/flush; aborts all work
// advance        in   1        EX stage register captures this cycle
// req_valid[i]   in   1        slot i (i=0,1) holds a mul/div op
// req_is_div[i]  in   1        1 = div/rem, 0 = mul
// req_sign1[i]   in   1        operand a signed
// req_sign2[i]   in   1        operand b signed
// req_get_hi[i]  in   1        mul: high half; div: remainder
// req_word32[i]  in   1        32-bit op
// req_a[i]       in   XLEN     operand a
// req_b[i]       in   XLEN     operand b
// stall          out  1        EX must hold
// resp_data[i]   out  XLEN     result for slot i, valid when stall=0
// mul_start      out  1        one-cycle start pulse to mul
// div_start      out  1        one-cycle start pulse to div
// div_abort      out  1        abort to div (its interrupt input)
// u_a, u_b       out  XLEN     registered unit operands (zero-extended low 32 bits if word32)
// u_sign1, u_sign2, u_get_hi  out 1  registered unit controls
// mul_ready      in   1        one-cycle pulse; mul_result valid
// div_ready      in   1        one-cycle pulse; div_result valid
// mul_result     in   XLEN     mul result
// div_result     in   XLEN     div result
// BEHAVIOUR
// Reset values: all outputs 0; state IDLE; done[1:0]=0; result regs 0.
// pend[i] = req_valid[i] & ~done[i]; stall = |pend (combinational), forced 0 while except=1.
// FSM, with g = granted slot:
// - IDLE:
//   - if except, stay;
//   - else if pend[0], g=0; else if pend[1], g=1;
//   - on grant, register operands/controls from slot g, go LAUNCH.
// - LAUNCH: assert mul_start or div_start (per req_is_div[g]) for exactly one cycle -> RUN.
// - RUN: hold u_* stable; wait for the matching ready.
//   - On ready: res[g] <= word32 ? sext(result[31:0]) : result; done[g] <= 1.
//   - If g=0 and pend[1], launch slot 1 next cycle: register its operands and go LAUNCH, with no idle gap.
//   - Otherwise go IDLE.
//   - The ready of the other unit is ignored.
// Latency:
// - request first visible at cycle T -> start pulse at T+1;
// - ready at cycle R -> resp_data valid and stall=0 at R+1 (if no further pend).
// Clearing done:
// - advance=1 with stall=0 clears done[1:0] at the next edge; new requests are accepted from that edge.
// - advance while stall=1 is a protocol error; assertion in sim, ignored in RTL.
// except:
// - div_abort=1 in the same cycle if the state is RUN or LAUNCH on div.
// - Next edge: state IDLE, done cleared, no start issued.
// - A ready arriving in the except cycle is discarded.
// Simultaneous events:
// - except wins over ready and over advance.
// - Both slots valid -> slot 0 always served first.
// - Slot 0 not valid -> slot 1 served directly.
// Arithmetic:
// - word32 operands are zero-extended into u_a/u_b; sign handling belongs to the unit via u_sign*.
// - Results are sign-extended from bit 31 when word32.
// Reset mid-operation: async clear of everything; the unit is reset by the same rst.
// resp_data[i] holds res[i] until the done clear; not defined for slots without a request.
// TESTING
// 1. Slot0 MUL 3*-5, signed, unit ready after 4 cycles
//    -> one mul_start pulse; resp_data[0]=64'hFFFF_FFFF_FFFF_FFF1; stall low 1 cycle after ready.
// 2. Slot0 MUL, slot1 DIVW a=-7, b=2
//    -> mul first, then div_start the cycle after mul_ready; resp_data[1]=64'hFFFF_FFFF_FFFF_FFFD.
// 3. Only slot1 DIV 100/7 with get_hi=1
//    -> div_start 1 cycle after request; resp_data[1]=2.
// 4. except while div RUN
//    -> div_abort=1 that cycle; state IDLE next; a late div_ready is ignored; stall=0.
// 5. Back-to-back: advance with stall=0, new slot0 MUL same edge
//    -> done cleared, new start issued 1 cycle later; old result not reused.
// 6. rst asserted mid-RUN
//    -> all outputs 0 immediately; after release, no spurious start.

Source files
------------

// File: rtl/mdu_arbiter_if.sv
// EX-stage view of the shared mul/div units: two issue-slot requests,
// per-slot results, and the registered operand/control bus to the units.
interface mdu_arbiter_if #(
    parameter int unsigned XLEN = 64
);
    logic                      except;
    logic                      advance;
    logic [1:0]                req_valid;
    logic [1:0]                req_is_div;
    logic [1:0]                req_sign1;
    logic [1:0]                req_sign2;
    logic [1:0]                req_get_hi;
    logic [1:0]                req_word32;
    logic [1:0][XLEN-1:0]      req_a;
    logic [1:0][XLEN-1:0]      req_b;
    logic                      stall;
    logic [1:0][XLEN-1:0]      resp_data;
    logic                      mul_start;
    logic                      div_start;
    logic                      div_abort;
    logic [XLEN-1:0]           u_a;
    logic [XLEN-1:0]           u_b;
    logic                      u_sign1;
    logic                      u_sign2;
    logic                      u_get_hi;
    logic                      mul_ready;
    logic                      div_ready;
    logic [XLEN-1:0]           mul_result;
    logic [XLEN-1:0]           div_result;

    modport slave (
        input  except, advance, req_valid, req_is_div, req_sign1, req_sign2, req_get_hi,
               req_word32, req_a, req_b, mul_ready, div_ready, mul_result, div_result,
        output stall, resp_data, mul_start, div_start, div_abort, u_a, u_b, u_sign1,
               u_sign2, u_get_hi
    );

    modport master (
        output except, advance, req_valid, req_is_div, req_sign1, req_sign2, req_get_hi,
               req_word32, req_a, req_b, mul_ready, div_ready, mul_result, div_result,
        input  stall, resp_data, mul_start, div_start, div_abort, u_a, u_b, u_sign1,
               u_sign2, u_get_hi
    );
endinterface

// File: rtl/mdu_arbiter.sv
// Shares one multi-cycle mul unit and one div unit between the two EX issue slots,
// serving slot 0 before slot 1 and stalling EX until every valid request is done.
module mdu_arbiter #(
    parameter int unsigned XLEN = 64
) (
    input logic          clk,
    input logic          rst,
    mdu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLaunch, StRun} state_e;

    state_e               state_q, state_d;
    logic                 g_q, g_d;
    logic                 is_div_q, is_div_d;
    logic                 word32_q, word32_d;
    logic [1:0]           done_q, done_d;
    logic [1:0][XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0]      u_a_q, u_a_d, u_b_q, u_b_d;
    logic                 u_sign1_q, u_sign1_d, u_sign2_q, u_sign2_d, u_get_hi_q, u_get_hi_d;
    logic                 mul_start_q, mul_start_d, div_start_q, div_start_d;
    logic [1:0]           pend;
    logic                 stall_c, load, load_slot, unit_ready;
    logic [XLEN-1:0]      unit_result;

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v, input logic w32);
        return w32 ? {{(XLEN-32){1'b0}}, v[31:0]} : v;
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v, input logic w32);
        return w32 ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Gated by rst so every output reads 0 while reset is held.
    assign pend    = bus.req_valid & ~done_q;
    assign stall_c = rst & ~bus.except & (|pend);

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        is_div_d    = is_div_q;
        word32_d    = word32_q;
        done_d      = done_q;
        res_d       = res_q;
        u_a_d       = u_a_q;
        u_b_d       = u_b_q;
        u_sign1_d   = u_sign1_q;
        u_sign2_d   = u_sign2_q;
        u_get_hi_d  = u_get_hi_q;
        mul_start_d = 1'b0;
        div_start_d = 1'b0;
        load        = 1'b0;
        load_slot   = 1'b0;
        unit_ready  = is_div_q ? bus.div_ready : bus.mul_ready;
        unit_result = is_div_q ? bus.div_result : bus.mul_result;

        if (bus.except) begin
            state_d = StIdle;
            done_d  = '0;
        end else begin
            if (bus.advance && !stall_c) begin
                done_d = '0;
            end
            unique case (state_q)
                StIdle: begin
                    if (pend[0]) begin
                        load      = 1'b1;
                        load_slot = 1'b0;
                    end else if (pend[1]) begin
                        load      = 1'b1;
                        load_slot = 1'b1;
                    end
                end
                StLaunch: state_d = StRun;
                StRun: begin
                    if (unit_ready) begin
                        res_d[g_q]  = sext32(unit_result, word32_q);
                        done_d[g_q] = 1'b1;
                        // Chain slot 1 straight into LAUNCH so there is no idle bubble.
                        if (!g_q && pend[1]) begin
                            load      = 1'b1;
                            load_slot = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (load) begin
            state_d     = StLaunch;
            g_d         = load_slot;
            is_div_d    = bus.req_is_div[load_slot];
            word32_d    = bus.req_word32[load_slot];
            u_a_d       = zext32(bus.req_a[load_slot], bus.req_word32[load_slot]);
            u_b_d       = zext32(bus.req_b[load_slot], bus.req_word32[load_slot]);
            u_sign1_d   = bus.req_sign1[load_slot];
            u_sign2_d   = bus.req_sign2[load_slot];
            u_get_hi_d  = bus.req_get_hi[load_slot];
            mul_start_d = ~bus.req_is_div[load_slot];
            div_start_d = bus.req_is_div[load_slot];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            g_q         <= 1'b0;
            is_div_q    <= 1'b0;
            word32_q    <= 1'b0;
            done_q      <= '0;
            res_q       <= '0;
            u_a_q       <= '0;
            u_b_q       <= '0;
            u_sign1_q   <= 1'b0;
            u_sign2_q   <= 1'b0;
            u_get_hi_q  <= 1'b0;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            is_div_q    <= is_div_d;
            word32_q    <= word32_d;
            done_q      <= done_d;
            res_q       <= res_d;
            u_a_q       <= u_a_d;
            u_b_q       <= u_b_d;
            u_sign1_q   <= u_sign1_d;
            u_sign2_q   <= u_sign2_d;
            u_get_hi_q  <= u_get_hi_d;
            mul_start_q <= mul_start_d;
            div_start_q <= div_start_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.resp_data = res_q;
    assign bus.mul_start = mul_start_q;
    assign bus.div_start = div_start_q;
    assign bus.div_abort = bus.except & is_div_q & ((state_q == StLaunch) || (state_q == StRun));
    assign bus.u_a       = u_a_q;
    assign bus.u_b       = u_b_q;
    assign bus.u_sign1   = u_sign1_q;
    assign bus.u_sign2   = u_sign2_q;
    assign bus.u_get_hi  = u_get_hi_q;

    // EX may only capture once the arbiter has released the stall.
    a_no_advance_in_stall: assert property (@(posedge clk) disable iff (!rst)
        !(bus.advance && stall_c));
endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed bench for mdu_arbiter: stimulus pushes expected unit starts and results into
// queues, a negedge monitor pops and compares them as the DUT presents them.
module tb_mdu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;
    int   n_starts = 0;
    logic stall_prev = 1'b0;

    typedef struct {
        bit          is_div;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  ctl;   // {sign1, sign2, get_hi}
    } start_t;

    typedef struct {
        logic [1:0]  mask;
        logic [63:0] r0;
        logic [63:0] r1;
    } resp_t;

    start_t start_q[$];
    resp_t  resp_q[$];
    start_t mon_s;
    resp_t  mon_r;

    mdu_arbiter_if #(.XLEN(64)) bus ();
    mdu_arbiter #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (bus.mul_start || bus.div_start) begin
                n_starts++;
                if (start_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_start: mul_start=%0b div_start=%0b, expected none",
                             bus.mul_start, bus.div_start);
                end else begin
                    mon_s = start_q.pop_front();
                    chk("start_kind", {bus.div_start, bus.mul_start}, mon_s.is_div ? 2'b10 : 2'b01);
                    chk("u_a", bus.u_a, mon_s.a);
                    chk("u_b", bus.u_b, mon_s.b);
                    chk("u_ctl", {bus.u_sign1, bus.u_sign2, bus.u_get_hi}, mon_s.ctl);
                end
            end
            if (stall_prev && !bus.stall && !bus.except && resp_q.size() != 0) begin
                mon_r = resp_q.pop_front();
                if (mon_r.mask[0]) chk("resp_data0", bus.resp_data[0], mon_r.r0);
                if (mon_r.mask[1]) chk("resp_data1", bus.resp_data[1], mon_r.r1);
            end
            stall_prev = bus.stall;
        end
    end

    task automatic clear_reqs();
        bus.req_valid  = '0;
        bus.req_is_div = '0;
        bus.req_sign1  = '0;
        bus.req_sign2  = '0;
        bus.req_get_hi = '0;
        bus.req_word32 = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
    endtask

    task automatic set_req(input int s, input bit dv, input bit s1, input bit s2, input bit hi,
                           input bit w, input logic [63:0] a, input logic [63:0] b);
        bus.req_valid[s]  = 1'b1;
        bus.req_is_div[s] = dv;
        bus.req_sign1[s]  = s1;
        bus.req_sign2[s]  = s2;
        bus.req_get_hi[s] = hi;
        bus.req_word32[s] = w;
        bus.req_a[s]      = a;
        bus.req_b[s]      = b;
    endtask

    // Returns at the negedge of the start cycle.
    task automatic wait_start(input bit is_div, input int exp_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (is_div ? bus.div_start : bus.mul_start) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL start_timeout: no %s start within 20 cycles, expected one",
                     is_div ? "div" : "mul");
        end else begin
            chk("start_cycle", cyc_cnt, exp_cyc);
        end
    endtask

    // Unit model: ready lat cycles after the start; glitch pulses the other unit's ready.
    task automatic run_unit(input bit is_div, input int lat, input logic [63:0] res,
                            input bit glitch, output int rdy_cyc);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            bus.mul_ready  = is_div ? (glitch && k == 1) : (k == lat);
            bus.div_ready  = is_div ? (k == lat) : (glitch && k == 1);
            bus.mul_result = is_div ? 64'hBAD : res;
            bus.div_result = is_div ? res : 64'hBAD;
        end
        rdy_cyc = cyc_cnt;
        @(posedge clk); #1;
        bus.mul_ready = 1'b0;
        bus.div_ready = 1'b0;
    endtask

    task automatic retire();
        bus.advance = 1'b1;
        @(posedge clk); #1;
        bus.advance = 1'b0;
        clear_reqs();
    endtask

    initial begin
        int t, r, snap;
        bus.except = 1'b0;
        bus.advance = 1'b0;
        bus.mul_ready = 1'b0;
        bus.div_ready = 1'b0;
        bus.mul_result = '0;
        bus.div_result = '0;
        clear_reqs();
        #2;
        chk("rst_stall", bus.stall, 0);
        chk("rst_starts", {bus.mul_start, bus.div_start, bus.div_abort}, 0);
        chk("rst_u_a", bus.u_a, 0);
        chk("rst_resp", {bus.resp_data[0], bus.resp_data[1]}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 1: slot0 signed MUL 3 * -5, ready 4 cycles after start
        @(posedge clk); #1;
        set_req(0, 0, 1, 1, 0, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
        t = cyc_cnt;
        start_q.push_back('{1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 3'b110});
        resp_q.push_back('{2'b01, 64'hFFFF_FFFF_FFFF_FFF1, 64'd0});
        @(negedge clk);
        chk("t1_stall_req", bus.stall, 1);
        wait_start(0, t + 1);
        run_unit(0, 4, 64'hFFFF_FFFF_FFFF_FFF1, 0, r);
        @(negedge clk);
        chk("t1_stall_done", bus.stall, 0);
        retire();

        // 2: slot0 MUL 6*7, slot1 DIVW -7/2; div starts the cycle after mul_ready
        set_req(0, 0, 0, 0, 0, 0, 64'd6, 64'd7);
        set_req(1, 1, 1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        t = cyc_cnt;
        start_q.push_back('{1'b0, 64'd6, 64'd7, 3'b000});
        start_q.push_back('{1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 3'b110});
        resp_q.push_back('{2'b11, 64'd42, 64'hFFFF_FFFF_FFFF_FFFD});
        wait_start(0, t + 1);
        run_unit(0, 3, 64'd42, 0, r);
        wait_start(1, r + 1);
        run_unit(1, 5, 64'h0000_0000_FFFF_FFFD, 0, r);
        @(negedge clk);
        chk("t2_stall_done", bus.stall, 0);
        retire();

        // 3: only slot1 DIV 100 rem 7; a stray mul_ready must be ignored
        set_req(1, 1, 0, 0, 1, 0, 64'd100, 64'd7);
        t = cyc_cnt;
        start_q.push_back('{1'b1, 64'd100, 64'd7, 3'b001});
        resp_q.push_back('{2'b10, 64'd0, 64'd2});
        wait_start(1, t + 1);
        run_unit(1, 4, 64'd2, 1, r);
        @(negedge clk);
        chk("t3_stall_done", bus.stall, 0);
        retire();

        // 4: except during div RUN; ready in and after the except cycle is dropped
        set_req(0, 1, 1, 1, 0, 0, 64'd50, 64'd5);
        t = cyc_cnt;
        start_q.push_back('{1'b1, 64'd50, 64'd5, 3'b110});
        wait_start(1, t + 1);
        @(posedge clk); #1;
        bus.except = 1'b1;
        clear_reqs();
        bus.div_ready = 1'b1;
        bus.div_result = 64'd123;
        @(negedge clk);
        chk("t4_abort", bus.div_abort, 1);
        chk("t4_stall_except", bus.stall, 0);
        @(posedge clk); #1;
        bus.except = 1'b0;
        @(negedge clk);
        chk("t4_abort_clear", bus.div_abort, 0);
        chk("t4_stall_after", bus.stall, 0);
        @(posedge clk); #1;
        bus.div_ready = 1'b0;
        @(negedge clk);
        chk("t4_res_kept", bus.resp_data[0], 64'd42);

        // 5: back-to-back via advance with stall=0 and a new slot0 MUL on the same edge
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0, 0, 64'd2, 64'd3);
        t = cyc_cnt;
        start_q.push_back('{1'b0, 64'd2, 64'd3, 3'b000});
        resp_q.push_back('{2'b01, 64'd6, 64'd0});
        wait_start(0, t + 1);
        run_unit(0, 2, 64'd6, 0, r);
        bus.advance = 1'b1;
        @(posedge clk); #1;
        bus.advance = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 64'd10, 64'd11);
        t = cyc_cnt;
        start_q.push_back('{1'b0, 64'd10, 64'd11, 3'b000});
        resp_q.push_back('{2'b01, 64'd110, 64'd0});
        @(negedge clk);
        chk("t5_stall_new", bus.stall, 1);
        wait_start(0, t + 1);
        run_unit(0, 3, 64'd110, 0, r);
        @(negedge clk);
        chk("t5_stall_done", bus.stall, 0);
        retire();

        // 6: reset asserted mid-RUN
        set_req(0, 0, 0, 0, 0, 0, 64'd5, 64'd5);
        t = cyc_cnt;
        start_q.push_back('{1'b0, 64'd5, 64'd5, 3'b000});
        wait_start(0, t + 1);
        @(posedge clk); #1;
        chk("t6_u_a_run", bus.u_a, 64'd5);
        rst = 1'b0;
        #1;
        chk("t6_stall", bus.stall, 0);
        chk("t6_starts", {bus.mul_start, bus.div_start, bus.div_abort}, 0);
        chk("t6_u_bus", {bus.u_a, bus.u_b}, 0);
        chk("t6_u_ctl", {bus.u_sign1, bus.u_sign2, bus.u_get_hi}, 0);
        chk("t6_resp", {bus.resp_data[0], bus.resp_data[1]}, 0);
        clear_reqs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        snap = n_starts;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_no_start", n_starts, snap);
        chk("start_q_drained", start_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog expired");
    end
endmodule
